// File: rtl/scoreboard_pkg.sv
// Shared scoreboard display definitions: seven-segment glyphs (bit0=a .. bit6=g)
// and the display-multiplexer state encodings.
package scoreboard_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef enum logic [1:0] {
        GAP_T = 2'd0,
        ONES  = 2'd1,
        GAP_O = 2'd2,
        TENS  = 2'd3
    } disp_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import scoreboard_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_mux.sv
// Time-multiplexed two-digit seven-segment driver with blank gaps between digits,
// frame-boundary digit sampling, leading-zero blanking and frame-based blinking.
module score_display_mux
    import scoreboard_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int GAP_CYCLES   = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic       blank_lead_i,
    input  logic       blink_i,
    output logic [6:0] seg_o,
    output logic [1:0] dig_o
);

    localparam int MAX_DWELL = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam int BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] REF_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    disp_state_t   state, next_state;
    logic [CW-1:0] dwell_cnt;
    logic          dwell_last;
    logic          frame_start;

    logic [3:0]    tens_sh, ones_sh;
    logic          blank_sh;

    logic [BW-1:0] blink_cnt, next_blink_cnt;
    logic          blink_on, next_blink_on;
    logic          blink_act, next_blink_act;

    logic [3:0]    dec_in;
    logic [6:0]    dec_seg;
    logic          tens_blank;
    logic [6:0]    next_seg;
    logic [1:0]    next_dig;

    bcd_to_seg7 u_dec (
        .bcd (dec_in),
        .seg (dec_seg)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= GAP_T;
            dwell_cnt <= '0;
        end else begin
            state     <= next_state;
            dwell_cnt <= (next_state != state) ? '0 : dwell_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        dwell_last = 1'b0;
        case (state)
            GAP_T: begin
                dwell_last = (dwell_cnt == GAP_LAST);
                if (dwell_last) next_state = ONES;
            end
            ONES: begin
                dwell_last = (dwell_cnt == REF_LAST);
                if (dwell_last) next_state = GAP_O;
            end
            GAP_O: begin
                dwell_last = (dwell_cnt == GAP_LAST);
                if (dwell_last) next_state = TENS;
            end
            TENS: begin
                dwell_last = (dwell_cnt == REF_LAST);
                if (dwell_last) next_state = GAP_T;
            end
            default: next_state = GAP_T;
        endcase
    end

    assign frame_start = (state == GAP_T) && dwell_last;

    // The first frame starting with blink_i high only arms the counter, so a
    // blink sequence always opens with BLINK_FRAMES full lit frames.
    always_comb begin
        next_blink_on  = blink_on;
        next_blink_cnt = blink_cnt;
        next_blink_act = blink_act;
        if (frame_start) begin
            if (!blink_i) begin
                next_blink_on  = 1'b1;
                next_blink_cnt = '0;
                next_blink_act = 1'b0;
            end else if (!blink_act) begin
                next_blink_act = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                next_blink_on  = ~blink_on;
                next_blink_cnt = '0;
            end else begin
                next_blink_cnt = blink_cnt + 1'b1;
            end
        end
    end

    // On the frame-start edge the shadow registers are still loading, so the
    // ones glyph must come straight from the input that is being captured.
    always_comb begin
        dec_in     = tens_sh;
        if (frame_start) begin
            dec_in = ones_i;
        end else if (next_state == ONES) begin
            dec_in = ones_sh;
        end
        tens_blank = blank_sh && (tens_sh == 4'd0);
        next_seg   = '0;
        next_dig   = 2'b00;
        if (next_blink_on) begin
            case (next_state)
                ONES: begin
                    next_dig = 2'b01;
                    next_seg = dec_seg;
                end
                TENS: begin
                    if (!tens_blank) begin
                        next_dig = 2'b10;
                        next_seg = dec_seg;
                    end
                end
                default: begin
                    next_dig = 2'b00;
                    next_seg = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tens_sh   <= '0;
            ones_sh   <= '0;
            blank_sh  <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            blink_act <= 1'b0;
            seg_o     <= '0;
            dig_o     <= 2'b00;
        end else begin
            if (frame_start) begin
                tens_sh  <= tens_i;
                ones_sh  <= ones_i;
                blank_sh <= blank_lead_i;
            end
            blink_cnt <= next_blink_cnt;
            blink_on  <= next_blink_on;
            blink_act <= next_blink_act;
            seg_o     <= next_seg;
            dig_o     <= next_dig;
        end
    end

endmodule
